// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump sequencer.
//   - Geometry of the flattened register bus (N_REGS x WORD_W).
//   - FSM state encoding and the optional header byte value.
package regdump_pkg;

  localparam int N_REGS         = 32;
  localparam int WORD_W         = 32;
  localparam int REGS_W         = N_REGS * WORD_W;
  localparam int IDX_W          = $clog2(N_REGS);
  localparam int BYTES_PER_WORD = WORD_W / 8;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_HDR  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    SEND = ST_SEND,
    DONE = ST_DONE,
    HDR  = ST_HDR
  } state_t;

endpackage

// File: rtl/regdump_word_ser.sv
// Word serializer: captures one WORD_W word on load and shifts it out
// MSB byte first. A byte is consumed on each cycle with send_en && ready.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   load            capture word, restart byte count
//   word            word to capture
//   send_en         upstream FSM is presenting tx_byte as valid
//   ready           downstream accepts this cycle
//   tx_byte         current MSB byte of the shift register
//   last_byte       final byte of the word is being accepted this cycle
module regdump_word_ser
  import regdump_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              send_en,
  input  logic              ready,
  output logic [7:0]        tx_byte,
  output logic              last_byte
);

  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              xfer;

  assign xfer      = send_en && ready;
  assign tx_byte   = shift_q[WORD_W-1 -: 8];
  assign last_byte = xfer && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= word;
      cnt_q   <= '0;
    end else if (xfer) begin
      shift_q <= {shift_q[WORD_W-9:0], 8'h00};
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_dump_seq.sv
// Register-file dump sequencer: on i_start (in IDLE) walks registers
// 0..N_REGS-1, latching each word in its LOAD cycle and streaming it MSB
// byte first over a valid/ready byte interface toward the UART TX.
// Build option: define REGDUMP_HEADER_EN to prefix each dump with 0xA5.
// Ports:
//   clk, i_rst_n    clock, synchronous active-low reset
//   i_start         dump request, honoured only in IDLE
//   i_registers     flattened register file, reg0 in the MSBs
//   i_tx_ready      TX accepts a byte this cycle
//   o_tx_data       byte to send, o_tx_valid qualifies it
//   o_busy          any state other than IDLE
//   o_done          one-cycle pulse after the last accepted byte
//   o_reg_idx       register currently being sent
//
// state | meaning
// IDLE  | waiting for i_start
// HDR   | presenting header byte (REGDUMP_HEADER_EN only)
// LOAD  | capturing word reg_idx into the serializer
// SEND  | presenting the word's bytes under valid/ready
// DONE  | o_done pulse, back to IDLE
module regfile_dump_seq
  import regdump_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [REGS_W-1:0] i_registers,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_reg_idx
);

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   reg_idx_q, reg_idx_nxt;
  logic               load, send_en, hdr_valid, last_byte;
  logic [7:0]         ser_byte;
  logic [WORD_W-1:0]  reg_words [N_REGS];

  for (genvar k = 0; k < N_REGS; k++) begin : g_unpack
    assign reg_words[k] = i_registers[REGS_W-1-k*WORD_W -: WORD_W];
  end

  regdump_word_ser u_ser (
    .clk       (clk),
    .rst_n     (i_rst_n),
    .load      (load),
    .word      (reg_words[reg_idx_q]),
    .send_en   (send_en),
    .ready     (i_tx_ready),
    .tx_byte   (ser_byte),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      reg_idx_q <= '0;
    end else begin
      state_q   <= state_nxt;
      reg_idx_q <= reg_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    reg_idx_nxt = reg_idx_q;
    load        = 1'b0;
    send_en     = 1'b0;
    hdr_valid   = 1'b0;
    o_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          reg_idx_nxt = '0;
`ifdef REGDUMP_HEADER_EN
          state_nxt   = HDR;
`else
          state_nxt   = LOAD;
`endif
        end
      end
      HDR: begin
        hdr_valid = 1'b1;
        if (i_tx_ready) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        send_en = 1'b1;
        if (last_byte) begin
          // Last register finishes the dump rather than wrapping the index.
          if (reg_idx_q == IDX_W'(N_REGS - 1)) begin
            state_nxt = DONE;
          end else begin
            reg_idx_nxt = reg_idx_q + IDX_W'(1);
            state_nxt   = LOAD;
          end
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_tx_valid = send_en || hdr_valid;
  assign o_tx_data  = hdr_valid ? HEADER_BYTE : (send_en ? ser_byte : 8'h00);
  assign o_busy     = (state_q != IDLE);
  assign o_reg_idx  = reg_idx_q;

endmodule
